// File: rtl/neuron_layer_pkg.sv
// Shared types and helpers for the neuron_layer_mac block.
//   state_e   : layer FSM states
//   clog2     : ceiling log2 (0 for n <= 1)
//   port_w    : clog2 clamped to at least 1 bit, used for index ports
//   params_ok : legality check of a parameter set (accumulator cannot wrap)
//   sat_relu  : clamp a rescaled accumulator to the signed DATA_W range, optional ReLU
package neuron_layer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        OUT  = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int port_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // The saturation path goes through a longint, so ACC_W is capped at 64.
    function automatic bit params_ok(input int n_neurons, input int n_inputs, input int data_w,
                                     input int acc_w, input int frac_w);
        return (n_neurons >= 1) && (n_inputs >= 1) && (data_w >= 2) && (acc_w <= 64) &&
               (frac_w >= 0) && (frac_w < acc_w) &&
               (acc_w >= 2 * data_w + clog2(n_inputs) + 1);
    endfunction

    function automatic longint sat_relu(input longint y, input int data_w, input bit relu_en);
        longint hi, lo, r;
        hi = (longint'(1) <<< (data_w - 1)) - 1;
        lo = -(longint'(1) <<< (data_w - 1));
        r  = y;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        if (relu_en && (r < 0)) r = 0;
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac_cell.sv
// One neuron: weight row + bias storage, accumulator and the output activation.
//   clk, rst           : clock, async active-low reset (clears weights, bias, accumulator)
//   wr_en/wr_addr/data : write weight (addr < N_INPUTS) or bias (addr == N_INPUTS)
//   load               : first element of a vector, acc = bias<<FRAC_W + x*w[idx]
//   accum              : later element, acc += x*w[idx]
//   finish             : result has been captured by the top, clear accumulator
//   idx, x             : element index and value shared by all neurons
//   res                : saturated / rectified result of the current accumulator
module neuron_mac_cell
    import neuron_layer_pkg::*;
#(
    parameter  int N_INPUTS = 4,
    parameter  int DATA_W   = 8,
    parameter  int ACC_W    = 20,
    parameter  int FRAC_W   = 0,
    parameter  bit RELU_EN  = 1'b1,
    localparam int AW       = port_w(N_INPUTS + 1),
    localparam int IW       = port_w(N_INPUTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load,
    input  logic              accum,
    input  logic              finish,
    input  logic [IW-1:0]     idx,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] res
);
    localparam int PW = 2 * DATA_W;

    // Entry N_INPUTS holds the bias.
    logic signed [DATA_W-1:0] w_q [N_INPUTS+1];
    logic signed [DATA_W-1:0] w_d [N_INPUTS+1];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PW-1:0]     prod;
    longint                   y, sat;

    always_comb begin
        // Product uses the stored weight, so a write in the same cycle only
        // affects later vectors.
        prod = PW'(signed'(x)) * PW'(w_q[idx]);

        w_d = w_q;
        if (wr_en) w_d[wr_addr] = signed'(wr_data);

        acc_d = acc_q;
        if (load)        acc_d = (ACC_W'(w_q[N_INPUTS]) <<< FRAC_W) + ACC_W'(prod);
        else if (accum)  acc_d = acc_q + ACC_W'(prod);
        else if (finish) acc_d = '0;

        y   = longint'(acc_q) >>> FRAC_W;
        sat = sat_relu(y, DATA_W, RELU_EN);
        res = DATA_W'(sat);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= N_INPUTS; i++) w_q[i] <= '0;
            acc_q <= '0;
        end else begin
            w_q   <= w_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/neuron_layer_mac.sv
// Fully-connected neuron layer: streamed inputs, N_NEURONS parallel MACs,
// bias + rescale + saturate (+ ReLU), result vector on a valid/ready port.
//   clk, rst            : clock, async active-low reset
//   wt_we/neuron/addr/data : host weight/bias write, accepted only in IDLE
//   wt_err              : one-cycle pulse when a write was dropped
//   in_valid/ready/data : input element stream, index order 0..N_INPUTS-1
//   out_valid/ready/data: result vector, neuron k in bits [k*DATA_W +: DATA_W]
//   busy                : FSM not in IDLE
module neuron_layer_mac
    import neuron_layer_pkg::*;
#(
    parameter  int N_NEURONS = 4,
    parameter  int N_INPUTS  = 4,
    parameter  int DATA_W    = 8,
    parameter  int ACC_W     = 20,
    parameter  int FRAC_W    = 0,
    parameter  bit RELU_EN   = 1'b1,
    localparam int NW        = port_w(N_NEURONS),
    localparam int AW        = port_w(N_INPUTS + 1),
    localparam int IW        = port_w(N_INPUTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wt_we,
    input  logic [NW-1:0]                 wt_neuron,
    input  logic [AW-1:0]                 wt_addr,
    input  logic [DATA_W-1:0]             wt_data,
    output logic                          wt_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*DATA_W-1:0]   out_data,
    output logic                          busy
);
    generate
        if (!params_ok(N_NEURONS, N_INPUTS, DATA_W, ACC_W, FRAC_W)) begin : g_param_err
            $error("neuron_layer_mac: illegal parameters (need ACC_W >= 2*DATA_W + clog2(N_INPUTS) + 1, ACC_W <= 64)");
        end
    endgenerate

    state_e                           state_q, state_d;
    logic [IW-1:0]                    idx_q, idx_d;
    logic [N_NEURONS*DATA_W-1:0]      out_data_q, out_data_d;
    logic                             wt_err_q, wt_err_d;
    logic [N_NEURONS-1:0][DATA_W-1:0] res;
    logic                             in_hs, last, wr_ok, load, accum, finish;

    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == MAC);
        in_hs    = in_valid && in_ready;
        last     = (idx_q == IW'(N_INPUTS - 1));
        load     = in_hs && (state_q == IDLE);
        accum    = in_hs && (state_q == MAC);
        finish   = (state_q == ACT);

        // Extra bit on the neuron compare: N_NEURONS may equal 2**NW.
        wr_ok    = wt_we && (state_q == IDLE) &&
                   ({1'b0, wt_neuron} < (NW+1)'(N_NEURONS)) &&
                   (wt_addr <= AW'(N_INPUTS));
        wt_err_d = wt_we && !wr_ok;

        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        if (in_hs) idx_d = last ? '0 : idx_q + 1'b1;

        case (state_q)
            IDLE:    if (in_hs) state_d = last ? ACT : MAC;
            MAC:     if (in_hs && last) state_d = ACT;
            ACT: begin
                state_d    = OUT;
                out_data_d = res;
            end
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            out_data_q <= '0;
            wt_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            wt_err_q   <= wt_err_d;
        end
    end

    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign wt_err    = wt_err_q;

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_cell
        neuron_mac_cell #(
            .N_INPUTS (N_INPUTS),
            .DATA_W   (DATA_W),
            .ACC_W    (ACC_W),
            .FRAC_W   (FRAC_W),
            .RELU_EN  (RELU_EN)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_ok && ({1'b0, wt_neuron} == (NW+1)'(k))),
            .wr_addr (wt_addr),
            .wr_data (wt_data),
            .load    (load),
            .accum   (accum),
            .finish  (finish),
            .idx     (idx_q),
            .x       (in_data),
            .res     (res[k])
        );
    end

endmodule

// File: tb/tb_neuron_layer_mac.sv
// Directed bench for neuron_layer_mac. Four instances share one stimulus stream:
//   a: RELU on, FRAC_W=0   b: RELU off, FRAC_W=0   c: RELU on, FRAC_W=2
//   d: 3 neurons with its own write strobe, to reach an out-of-range neuron index.
module tb_neuron_layer_mac;
    logic       clk = 1'b0, rst = 1'b0;
    logic       wt_we = 1'b0, wt_we_d = 1'b0;
    logic       wt_neuron = 1'b0;
    logic [1:0] wt_nrn_d = 2'd0;
    logic [1:0] wt_addr = 2'd0;
    logic [7:0] wt_data = 8'd0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic        a_err, a_ir, a_ov, a_busy;
    logic        b_err, b_ir, b_ov, b_busy;
    logic        c_err, c_ir, c_ov, c_busy;
    logic        d_err, d_ir, d_ov, d_busy;
    logic [15:0] a_od, b_od, c_od;
    logic [23:0] d_od;

    int n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    neuron_layer_mac #(.N_NEURONS(2), .N_INPUTS(3), .DATA_W(8), .ACC_W(20), .FRAC_W(0), .RELU_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .wt_we(wt_we), .wt_neuron(wt_neuron), .wt_addr(wt_addr), .wt_data(wt_data),
        .wt_err(a_err), .in_valid(in_valid), .in_ready(a_ir), .in_data(in_data), .out_valid(a_ov),
        .out_ready(out_ready), .out_data(a_od), .busy(a_busy));
    neuron_layer_mac #(.N_NEURONS(2), .N_INPUTS(3), .DATA_W(8), .ACC_W(20), .FRAC_W(0), .RELU_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .wt_we(wt_we), .wt_neuron(wt_neuron), .wt_addr(wt_addr), .wt_data(wt_data),
        .wt_err(b_err), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data), .out_valid(b_ov),
        .out_ready(out_ready), .out_data(b_od), .busy(b_busy));
    neuron_layer_mac #(.N_NEURONS(2), .N_INPUTS(3), .DATA_W(8), .ACC_W(20), .FRAC_W(2), .RELU_EN(1'b1)) dut_c (
        .clk(clk), .rst(rst), .wt_we(wt_we), .wt_neuron(wt_neuron), .wt_addr(wt_addr), .wt_data(wt_data),
        .wt_err(c_err), .in_valid(in_valid), .in_ready(c_ir), .in_data(in_data), .out_valid(c_ov),
        .out_ready(out_ready), .out_data(c_od), .busy(c_busy));
    neuron_layer_mac #(.N_NEURONS(3), .N_INPUTS(3), .DATA_W(8), .ACC_W(20), .FRAC_W(0), .RELU_EN(1'b1)) dut_d (
        .clk(clk), .rst(rst), .wt_we(wt_we_d), .wt_neuron(wt_nrn_d), .wt_addr(wt_addr), .wt_data(wt_data),
        .wt_err(d_err), .in_valid(in_valid), .in_ready(d_ir), .in_data(in_data), .out_valid(d_ov),
        .out_ready(out_ready), .out_data(d_od), .busy(d_busy));

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 8'h%02h expected 8'h%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int n, input int a, input int d);
        wt_we = 1'b1; wt_neuron = 1'(n); wt_addr = 2'(a); wt_data = 8'(d);
        tick();
        wt_we = 1'b0;
    endtask

    task automatic load(input int w00, input int w01, input int w02, input int b0,
                        input int w10, input int w11, input int w12, input int b1);
        wr(0, 0, w00); wr(0, 1, w01); wr(0, 2, w02); wr(0, 3, b0);
        wr(1, 0, w10); wr(1, 1, w11); wr(1, 2, w12); wr(1, 3, b1);
    endtask

    // Returns at the negedge after the third handshake (DUT is then in ACT).
    task automatic send3(input int x0, input int x1, input int x2);
        in_valid = 1'b1;
        in_data = 8'(x0); tick();
        in_data = 8'(x1); tick();
        in_data = 8'(x2); tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] model(input int w0, input int w1, input int w2, input int b,
                                         input int x0, input int x1, input int x2,
                                         input int frac, input bit relu);
        int acc, y;
        acc = (b <<< frac) + w0 * x0 + w1 * x1 + w2 * x2;
        y = acc >>> frac;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        if (relu && (y < 0)) y = 0;
        return 8'(y);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk1("rst_a_ir", a_ir, 1'b1); chk1("rst_a_ov", a_ov, 1'b0); chk1("rst_a_busy", a_busy, 1'b0);
        chk1("rst_a_err", a_err, 1'b0); chk8("rst_a_od0", a_od[7:0], 8'h00); chk8("rst_a_od1", a_od[15:8], 8'h00);
        chk1("rst_b_ir", b_ir, 1'b1); chk1("rst_b_ov", b_ov, 1'b0); chk1("rst_b_busy", b_busy, 1'b0);
        chk1("rst_c_ir", c_ir, 1'b1); chk1("rst_c_ov", c_ov, 1'b0); chk1("rst_c_busy", c_busy, 1'b0);
        chk1("rst_d_ir", d_ir, 1'b1); chk1("rst_d_busy", d_busy, 1'b0); chk1("rst_d_err", d_err, 1'b0);
        tick();
        rst = 1'b1;

        // Basic vector and latency
        load(1, 2, 3, 1, -1, 0, 2, 0);
        out_ready = 1'b1;
        send3(4, 5, 6);
        chk1("s1_act_ov", a_ov, 1'b0); chk1("s1_act_ir", a_ir, 1'b0); chk1("s1_act_busy", a_busy, 1'b1);
        tick();
        chk1("s1_ov", a_ov, 1'b1); chk1("s1_d_ov", d_ov, 1'b1);
        chk8("s1_a_n0", a_od[7:0], 8'd33); chk8("s1_a_n1", a_od[15:8], 8'd8);
        chk8("s1_b_n0", b_od[7:0], 8'd33); chk8("s1_b_n1", b_od[15:8], 8'd8);
        chk8("s1_c_n0", c_od[7:0], 8'd9);  chk8("s1_c_n1", c_od[15:8], 8'd2);
        tick();
        chk1("s1_done_ov", a_ov, 1'b0); chk1("s1_done_busy", a_busy, 1'b0);

        // Output back-pressure with a waiting input
        out_ready = 1'b0;
        send3(4, 5, 6);
        tick();
        in_valid = 1'b1; in_data = 8'd50;
        for (int i = 0; i < 5; i++) begin
            chk1("bp_ov", a_ov, 1'b1); chk1("bp_ir", a_ir, 1'b0);
            chk8("bp_n0", a_od[7:0], 8'd33); chk8("bp_n1", a_od[15:8], 8'd8);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk1("bp_rel_ov", a_ov, 1'b0); chk1("bp_rel_ir", a_ir, 1'b1);
        send3(4, 5, 6);
        tick();
        chk8("bp_next_n0", a_od[7:0], 8'd33); chk8("bp_next_n1", a_od[15:8], 8'd8);
        tick();

        // Write in the same cycle as the first handshake: applied, MAC uses old weight
        in_valid = 1'b1; in_data = 8'd4;
        wt_we = 1'b1; wt_neuron = 1'b0; wt_addr = 2'd0; wt_data = 8'd7;
        tick();
        wt_we = 1'b0;
        chk1("wfirst_err", a_err, 1'b0);
        in_data = 8'd5; tick();
        in_data = 8'd6; tick();
        in_valid = 1'b0;
        tick();
        chk8("wfirst_old_n0", a_od[7:0], 8'd33);
        tick();
        send3(4, 5, 6);
        tick();
        chk8("wfirst_new_a_n0", a_od[7:0], 8'd57); chk8("wfirst_new_c_n0", c_od[7:0], 8'd15);
        tick();
        wr(0, 0, 1);

        // Write while busy is dropped
        in_valid = 1'b1; in_data = 8'd4; tick();
        in_data = 8'd5;
        wt_we = 1'b1; wt_neuron = 1'b0; wt_addr = 2'd0; wt_data = 8'd99;
        tick();
        wt_we = 1'b0;
        chk1("busywr_a_err", a_err, 1'b1); chk1("busywr_c_err", c_err, 1'b1);
        in_data = 8'd6; tick();
        in_valid = 1'b0;
        chk1("busywr_err_pulse", a_err, 1'b0);
        tick();
        chk8("busywr_n0", a_od[7:0], 8'd33); chk8("busywr_n1", a_od[15:8], 8'd8);
        tick();

        // Out-of-range neuron index on the 3-neuron instance
        wt_we_d = 1'b1; wt_nrn_d = 2'd3; wt_addr = 2'd0; wt_data = 8'd55;
        tick();
        wt_we_d = 1'b0;
        chk1("range_d_err", d_err, 1'b1); chk1("range_a_err", a_err, 1'b0);
        wt_we_d = 1'b1; wt_nrn_d = 2'd2; wt_addr = 2'd3; wt_data = 8'd5;
        tick();
        wt_we_d = 1'b0;
        chk1("inrange_d_err", d_err, 1'b0);
        send3(4, 5, 6);
        tick();
        chk8("range_a_n0", a_od[7:0], 8'd33); chk8("range_a_n1", a_od[15:8], 8'd8);
        chk8("range_d_n0", d_od[7:0], 8'd0);  chk8("range_d_n1", d_od[15:8], 8'd0);
        chk8("range_d_n2", d_od[23:16], 8'd5);
        tick();

        // Saturation and ReLU
        load(100, 100, 100, 1, -10, -10, -10, 0);
        send3(5, 5, 5);
        tick();
        chk8("sat_a_n0", a_od[7:0], 8'd127); chk8("sat_a_n1", a_od[15:8], 8'd0);
        chk8("sat_b_n0", b_od[7:0], 8'd127); chk8("sat_b_n1", b_od[15:8], 8'h80);
        chk8("sat_c_n0", c_od[7:0], 8'd127); chk8("sat_c_n1", c_od[15:8], 8'd0);
        tick();
        send3(2, 2, 2);
        tick();
        chk8("sat2_a_n0", a_od[7:0], 8'd127); chk8("sat2_a_n1", a_od[15:8], 8'd0);
        chk8("sat2_b_n1", b_od[15:8], 8'hC4); chk8("sat2_c_n0", c_od[7:0], 8'd127);
        tick();

        // Asynchronous reset mid-vector
        load(1, 2, 3, 1, -1, 0, 2, 0);
        in_valid = 1'b1; in_data = 8'd4; tick();
        in_data = 8'd5; tick();
        in_valid = 1'b0;
        chk1("mid_busy", a_busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("arst_ov", a_ov, 1'b0); chk1("arst_busy", a_busy, 1'b0); chk1("arst_ir", a_ir, 1'b1);
        tick();
        rst = 1'b1;
        send3(4, 5, 6);
        tick();
        chk1("arst_vec_ov", a_ov, 1'b1);
        chk8("arst_a_n0", a_od[7:0], 8'd0); chk8("arst_a_n1", a_od[15:8], 8'd0);
        chk8("arst_c_n0", c_od[7:0], 8'd0); chk8("arst_d_n2", d_od[23:16], 8'd0);
        tick();

        // Fractional rescale
        load(4, 4, 4, 4, 0, 0, 0, 0);
        send3(1, 2, 3);
        tick();
        chk8("frac_c_n0", c_od[7:0], 8'd10); chk8("frac_a_n0", a_od[7:0], 8'd28);
        tick();

        // Random weights, inputs, gaps and output stalls against the model
        for (int v = 0; v < 1000; v++) begin
            int w [2][3];
            int bb [2];
            int x [3];
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 3; i++) w[k][i] = int'($urandom_range(0, 255)) - 128;
                bb[k] = int'($urandom_range(0, 255)) - 128;
            end
            for (int i = 0; i < 3; i++) x[i] = int'($urandom_range(0, 255)) - 128;
            load(w[0][0], w[0][1], w[0][2], bb[0], w[1][0], w[1][1], w[1][2], bb[1]);
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                in_valid = 1'b1; in_data = 8'(x[i]);
                tick();
                in_valid = 1'b0;
            end
            for (int t = 0; t < 8 && !a_ov; t++) tick();
            chk1("rnd_ov", a_ov, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
            for (int k = 0; k < 2; k++) begin
                chk8("rnd_a", a_od[k*8 +: 8], model(w[k][0], w[k][1], w[k][2], bb[k], x[0], x[1], x[2], 0, 1'b1));
                chk8("rnd_b", b_od[k*8 +: 8], model(w[k][0], w[k][1], w[k][2], bb[k], x[0], x[1], x[2], 0, 1'b0));
                chk8("rnd_c", c_od[k*8 +: 8], model(w[k][0], w[k][1], w[k][2], bb[k], x[0], x[1], x[2], 2, 1'b1));
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
